// File: rtl/gpio_ctrl.sv
// rtl/gpio_ctrl.sv - GPIO controller with set/clear outputs, pin interrupts and aggregated irq.
// Per-pin input debounce is compiled in when GPIO_DEBOUNCE_EN is defined.
module gpio_ctrl #(
    parameter int GPIO_NUM = 32,
    parameter int DBC_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          waddr_i,
    input  logic [31:0]         data_i,
    input  logic [3:0]          sel_i,
    input  logic                we_i,
    input  logic [7:0]          raddr_i,
    input  logic                rd_i,
    output logic [31:0]         data_o,
    input  logic [GPIO_NUM-1:0] gpio_in,
    output logic [GPIO_NUM-1:0] gpio_oe,
    output logic [GPIO_NUM-1:0] gpio_out,
    output logic                irq_o
);

    localparam logic [7:0] OFF_DIN  = 8'h00;
    localparam logic [7:0] OFF_OPT  = 8'h04;
    localparam logic [7:0] OFF_OEC  = 8'h08;
    localparam logic [7:0] OFF_OMD  = 8'h0C;
    localparam logic [7:0] OFF_OSET = 8'h10;
    localparam logic [7:0] OFF_OCLR = 8'h14;
    localparam logic [7:0] OFF_IEN  = 8'h18;
    localparam logic [7:0] OFF_ITYP = 8'h1C;
    localparam logic [7:0] OFF_IPOL = 8'h20;
    localparam logic [7:0] OFF_IPND = 8'h24;
    localparam logic [7:0] OFF_DBC  = 8'h28;

    logic [GPIO_NUM-1:0] opt;
    logic [GPIO_NUM-1:0] oec;
    logic [GPIO_NUM-1:0] omd;
    logic [GPIO_NUM-1:0] ien;
    logic [GPIO_NUM-1:0] ityp;
    logic [GPIO_NUM-1:0] ipol;
    logic [GPIO_NUM-1:0] ipnd;

    logic [GPIO_NUM-1:0] sync1;
    logic [GPIO_NUM-1:0] sync2;
    logic [GPIO_NUM-1:0] din_f;
    logic [GPIO_NUM-1:0] din_prev;
    logic [GPIO_NUM-1:0] evt;
    logic [GPIO_NUM-1:0] hit;
    logic [31:0]         dbc_rd;

    logic [31:0]         bmask;
    logic [31:0]         wbits;
    logic [GPIO_NUM-1:0] wmask;
    logic [GPIO_NUM-1:0] wset;

    // Byte lanes not enabled keep their old contents in every RW register.
    assign bmask = {{8{sel_i[3]}}, {8{sel_i[2]}}, {8{sel_i[1]}}, {8{sel_i[0]}}};
    assign wbits = data_i & bmask;
    assign wmask = bmask[GPIO_NUM-1:0];
    assign wset  = wbits[GPIO_NUM-1:0];

    logic wr_opt, wr_oec, wr_omd, wr_oset, wr_oclr;
    logic wr_ien, wr_ityp, wr_ipol, wr_ipnd, wr_dbc;

    assign wr_opt  = we_i && (waddr_i == OFF_OPT);
    assign wr_oec  = we_i && (waddr_i == OFF_OEC);
    assign wr_omd  = we_i && (waddr_i == OFF_OMD);
    assign wr_oset = we_i && (waddr_i == OFF_OSET);
    assign wr_oclr = we_i && (waddr_i == OFF_OCLR);
    assign wr_ien  = we_i && (waddr_i == OFF_IEN);
    assign wr_ityp = we_i && (waddr_i == OFF_ITYP);
    assign wr_ipol = we_i && (waddr_i == OFF_IPOL);
    assign wr_ipnd = we_i && (waddr_i == OFF_IPND);
    assign wr_dbc  = we_i && (waddr_i == OFF_DBC);

    always_ff @(posedge clk) begin
        if (rst) begin
            opt  <= '0;
            oec  <= '0;
            omd  <= '0;
            ien  <= '0;
            ityp <= '0;
            ipol <= '0;
        end else begin
            if (wr_opt)
                opt <= (opt & ~wmask) | wset;
            else if (wr_oset)
                opt <= opt | wset;
            else if (wr_oclr)
                opt <= opt & ~wset;
            if (wr_oec)
                oec <= (oec & ~wmask) | wset;
            if (wr_omd)
                omd <= (omd & ~wmask) | wset;
            if (wr_ien)
                ien <= (ien & ~wmask) | wset;
            if (wr_ityp)
                ityp <= (ityp & ~wmask) | wset;
            if (wr_ipol)
                ipol <= (ipol & ~wmask) | wset;
        end
    end

    // Open-drain pins drive low when OPT=0 and float when OPT=1.
    assign gpio_oe  = oec & ~(omd & opt);
    assign gpio_out = oec & ~omd & opt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= gpio_in;
            sync2 <= sync1;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    logic [DBC_W-1:0] dbc;
    logic [DBC_W-1:0] cnt [GPIO_NUM];
    logic [31:0]      dbc_mask;

    assign dbc_mask = bmask;
    assign dbc_rd   = 32'(dbc);

    always_ff @(posedge clk) begin
        if (rst)
            dbc <= '0;
        else if (wr_dbc)
            dbc <= (dbc & ~dbc_mask[DBC_W-1:0]) | wbits[DBC_W-1:0];
    end

    // A pin's filtered value follows the synchronised input only after it has
    // disagreed for DBC consecutive cycles; any agreement restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            din_f <= '0;
            for (int i = 0; i < GPIO_NUM; i++)
                cnt[i] <= '0;
        end else begin
            for (int i = 0; i < GPIO_NUM; i++) begin
                if (sync2[i] != din_f[i]) begin
                    if (cnt[i] == dbc) begin
                        din_f[i] <= sync2[i];
                        cnt[i]   <= '0;
                    end else if (cnt[i] != '1) begin
                        cnt[i] <= cnt[i] + DBC_W'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end
`else
    logic [DBC_W-1:0] dbc_zero;
    logic             dbc_wr_unused;

    assign din_f         = sync2;
    assign dbc_zero      = '0;
    assign dbc_rd        = 32'(dbc_zero);
    assign dbc_wr_unused = wr_dbc;
`endif

    // Level mode matches IPOL; edge mode needs a change that lands on IPOL.
    assign hit = (~ityp & ~(din_f ^ ipol)) |
                 (ityp & (din_f ^ din_prev) & ~(din_f ^ ipol));

    always_ff @(posedge clk) begin
        if (rst) begin
            din_prev <= '0;
            evt      <= '0;
            ipnd     <= '0;
            irq_o    <= 1'b0;
        end else begin
            din_prev <= din_f;
            evt      <= hit;
            ipnd     <= (ipnd & ~(wr_ipnd ? wset : '0)) | evt;
            irq_o    <= |(ipnd & ien);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_o <= '0;
        end else if (rd_i) begin
            case (raddr_i)
                OFF_DIN:  data_o <= 32'(din_f);
                OFF_OPT:  data_o <= 32'(opt);
                OFF_OEC:  data_o <= 32'(oec);
                OFF_OMD:  data_o <= 32'(omd);
                OFF_IEN:  data_o <= 32'(ien);
                OFF_ITYP: data_o <= 32'(ityp);
                OFF_IPOL: data_o <= 32'(ipol);
                OFF_IPND: data_o <= 32'(ipnd);
                OFF_DBC:  data_o <= dbc_rd;
                default:  data_o <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb/tb_gpio_ctrl.sv - randomized self-checking bench for gpio_ctrl against a register-level model.
module tb_gpio_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  waddr_i;
    logic [31:0] data_i;
    logic [3:0]  sel_i;
    logic        we_i;
    logic [7:0]  raddr_i;
    logic        rd_i;
    logic [31:0] data_o;
    logic [31:0] gpio_in;
    logic [31:0] gpio_oe;
    logic [31:0] gpio_out;
    logic        irq_o;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_opt, m_oec, m_omd, m_ien, m_ityp, m_ipol;
    logic [15:0] m_dbc;
    logic [31:0] h1, h2;

    gpio_ctrl #(.GPIO_NUM(32), .DBC_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .waddr_i  (waddr_i),
        .data_i   (data_i),
        .sel_i    (sel_i),
        .we_i     (we_i),
        .raddr_i  (raddr_i),
        .rd_i     (rd_i),
        .data_o   (data_o),
        .gpio_in  (gpio_in),
        .gpio_oe  (gpio_oe),
        .gpio_out (gpio_out),
        .irq_o    (irq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Pads are sampled at each edge; h2 is what DIN shows two edges later.
    task automatic tick();
        logic [31:0] s;
        s = gpio_in;
        @(posedge clk);
        #1;
        h2 = h1;
        h1 = s;
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] s);
        logic [31:0] m;
        for (int b = 0; b < 4; b++)
            m[b*8 +: 8] = s[b] ? 8'hFF : 8'h00;
        return m;
    endfunction

    task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] bm, nd;
        bm = lane_mask(s);
        nd = d & bm;
        case (a)
            8'h04: m_opt  = (m_opt & ~bm) | nd;
            8'h08: m_oec  = (m_oec & ~bm) | nd;
            8'h0C: m_omd  = (m_omd & ~bm) | nd;
            8'h10: m_opt  = m_opt | nd;
            8'h14: m_opt  = m_opt & ~nd;
            8'h18: m_ien  = (m_ien & ~bm) | nd;
            8'h1C: m_ityp = (m_ityp & ~bm) | nd;
            8'h20: m_ipol = (m_ipol & ~bm) | nd;
`ifdef GPIO_DEBOUNCE_EN
            8'h28: begin
                logic [31:0] t;
                t = ({16'h0, m_dbc} & ~bm) | nd;
                m_dbc = t[15:0];
            end
`endif
            default: ;
        endcase
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] a, input logic [31:0] din);
        case (a)
            8'h00: return din;
            8'h04: return m_opt;
            8'h08: return m_oec;
            8'h0C: return m_omd;
            8'h18: return m_ien;
            8'h1C: return m_ityp;
            8'h20: return m_ipol;
`ifdef GPIO_DEBOUNCE_EN
            8'h28: return {16'h0, m_dbc};
`endif
            default: return 32'h0;
        endcase
    endfunction

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        waddr_i = a;
        data_i  = d;
        sel_i   = s;
        we_i    = 1'b1;
        tick();
        we_i    = 1'b0;
        model_write(a, d, s);
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] v, output logic [31:0] din_exp);
        raddr_i = a;
        rd_i    = 1'b1;
        din_exp = h2;
        tick();
        rd_i    = 1'b0;
        v       = data_o;
    endtask

    task automatic check_pads(input string tag);
        logic [31:0] eoe, eout;
        for (int p = 0; p < 32; p++) begin
            if (!m_oec[p]) begin
                eoe[p] = 1'b0; eout[p] = 1'b0;
            end else if (!m_omd[p]) begin
                eoe[p] = 1'b1; eout[p] = m_opt[p];
            end else begin
                eoe[p] = !m_opt[p]; eout[p] = 1'b0;
            end
        end
        check({tag, "_oe"}, gpio_oe, eoe);
        check({tag, "_out"}, gpio_out, eout);
    endtask

    logic [7:0] addrs [14] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18,
                               8'h1C, 8'h20, 8'h28, 8'h2C, 8'h40, 8'h06, 8'hFC};

    initial begin
        logic [31:0] v, de;
        m_opt = 0; m_oec = 0; m_omd = 0; m_ien = 0; m_ityp = 0; m_ipol = 0; m_dbc = 0;
        waddr_i = 0; data_i = 0; sel_i = 0; we_i = 0; raddr_i = 0; rd_i = 0;
        gpio_in = 32'hFFFF_FFFF;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        h1 = 0;
        h2 = 0;

        check("rst_oe", gpio_oe, 32'h0);
        check("rst_out", gpio_out, 32'h0);
        check("rst_irq", {31'h0, irq_o}, 32'h0);
        check("rst_data", data_o, 32'h0);
        rd(8'h24, v, de);
        check("rst_ipnd", v, 32'h0);
        rd(8'h00, v, de);
        check("rst_din_early", v, 32'h0);
        rd(8'h00, v, de);
`ifdef GPIO_DEBOUNCE_EN
        check("rst_din_3", v, 32'h0);
        rd(8'h00, v, de);
`endif
        check("rst_din", v, 32'hFFFF_FFFF);
        for (int a = 4; a <= 8'h28; a += 4) begin
            rd(8'(a), v, de);
            if (a != 8'h24)
                check($sformatf("rst_reg_%02h", a), v, 32'h0);
        end
        wr(8'h24, 32'hFFFF_FFFF, 4'hF);
        rd(8'h24, v, de);
        check("ipnd_clear_all", v, 32'h0);

        wr(8'h04, 32'h0000_00F0, 4'hF);
        wr(8'h08, 32'h0000_00FF, 4'hF);
        wr(8'h10, 32'h0000_000F, 4'hF);
        wr(8'h14, 32'h0000_0030, 4'hF);
        rd(8'h04, v, de);
        check("setclr_opt", v, 32'h0000_00CF);
        check("setclr_pad", {24'h0, gpio_out[7:0]}, 32'h0000_00CF);
        rd(8'h10, v, de);
        check("oset_reads0", v, 32'h0);
        wr(8'h0C, 32'h0000_0001, 4'hF);
        check("od_oe0", {31'h0, gpio_oe[0]}, 32'h0);
        check("od_out0", {31'h0, gpio_out[0]}, 32'h0);
        check_pads("od");

        wr(8'h04, 32'h0, 4'hF);
        wr(8'h04, 32'h1234_5678, 4'b0101);
        rd(8'h04, v, de);
        check("byte_en", v, 32'h0034_0078);

        gpio_in[3] = 1'b0;
        repeat (4) tick();
        wr(8'h18, 32'h8, 4'hF);
        wr(8'h1C, 32'h8, 4'hF);
        wr(8'h20, 32'h8, 4'hF);
        wr(8'h24, 32'hFFFF_FFFF, 4'hF);
        repeat (2) tick();
        check("edge_idle_irq", {31'h0, irq_o}, 32'h0);
        gpio_in[3] = 1'b1;
        repeat (4) tick();
        check("edge_irq_c4", {31'h0, irq_o}, 32'h0);
        tick();
        check("edge_irq_c5", {31'h0, irq_o}, 32'h1);
        rd(8'h24, v, de);
        check("edge_ipnd", v, 32'h8);
        wr(8'h24, 32'h8, 4'hF);
        check("edge_w1c_c1", {31'h0, irq_o}, 32'h1);
        tick();
        check("edge_w1c_c2", {31'h0, irq_o}, 32'h0);

        wr(8'h18, 32'h20, 4'hF);
        gpio_in[5] = 1'b0;
        repeat (6) tick();
        check("lvl_irq", {31'h0, irq_o}, 32'h1);
        wr(8'h24, 32'h20, 4'hF);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("lvl_hold_%0d", k), {31'h0, irq_o}, 32'h1);
        end
        gpio_in[5] = 1'b1;
        repeat (4) tick();
        wr(8'h24, 32'h20, 4'hF);
        tick();
        check("lvl_release", {31'h0, irq_o}, 32'h0);

`ifdef GPIO_DEBOUNCE_EN
        wr(8'h28, 32'h4, 4'hF);
        rd(8'h28, v, de);
        check("dbc_reg", v, 32'h4);
        wr(8'h18, 32'h0, 4'hF);
        wr(8'h24, 32'hFFFF_FFFF, 4'hF);
        gpio_in[0] = 1'b0;
        repeat (3) tick();
        gpio_in[0] = 1'b1;
        repeat (10) tick();
        rd(8'h00, v, de);
        check("glitch_din", {31'h0, v[0]}, 32'h1);
        rd(8'h24, v, de);
        check("glitch_ipnd", {31'h0, v[0]}, 32'h0);
        gpio_in[0] = 1'b0;
        repeat (12) tick();
        gpio_in[0] = 1'b1;
        repeat (6) tick();
        rd(8'h00, v, de);
        check("pulse_din_c7", {31'h0, v[0]}, 32'h0);
        rd(8'h00, v, de);
        check("pulse_din_c8", {31'h0, v[0]}, 32'h1);
        tick();
        gpio_in[0] = 1'b0;
        repeat (10) tick();
`endif

        for (int it = 0; it < 300; it++) begin
            logic [7:0] a;
            if ($urandom_range(0, 3) == 0)
                gpio_in = $urandom;
            a = addrs[$urandom_range(0, 13)];
            if ($urandom_range(0, 1) == 0) begin
                wr(a, $urandom, 4'($urandom_range(0, 15)));
            end else begin
                rd(a, v, de);
`ifdef GPIO_DEBOUNCE_EN
                if (a != 8'h00)
                    check($sformatf("rnd_rd_%02h", a), v, model_read(a, de));
`else
                check($sformatf("rnd_rd_%02h", a), v, model_read(a, de));
`endif
            end
            check_pads("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
